scan_line_sequencer: RTL and testbench

// Sequences one scan frame of a linear film sensor: per line, waits for downstream

---
 rtl/scan_line_sequencer.sv | 172 +++++++++++++++++
 tb/tb_scan_line_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_line_sequencer.sv
// Frame sequencer for a linear film sensor: per line waits for buffer room, pulses the
// shift gate, integrates, opens the pixel window, then steps the film transport.
module scan_line_sequencer #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SH_WIDTH   = 4,
    parameter int unsigned STEP_WIDTH = 8
) (
    input  logic             rx_clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_pixels,
    input  logic [CNT_W-1:0] cfg_lines,
    input  logic [CNT_W-1:0] cfg_integ,
    input  logic             fifo_afull,
    output logic             sensor_sh,
    output logic             line_valid,
    output logic             motor_step,
    output logic [CNT_W-1:0] line_idx,
    output logic             busy,
    output logic             done,
    output logic             err_ovf
);

    typedef enum logic [2:0] {
        StIdle, StWaitRdy, StSh, StInteg, StRead, StStep, StDone
    } state_e;

    localparam logic [CNT_W-1:0] ShLast   = CNT_W'(SH_WIDTH - 1);
    localparam logic [CNT_W-1:0] StepLast = CNT_W'(STEP_WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] lines_q, lines_d;
    logic [CNT_W-1:0] integ_q, integ_d;
    logic [CNT_W-1:0] line_idx_q, line_idx_d;
    logic             err_ovf_q, err_ovf_d;
    logic             sh_q, sh_d;
    logic             lv_q, lv_d;
    logic             ms_q, ms_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pix_d      = pix_q;
        lines_d    = lines_q;
        integ_d    = integ_q;
        line_idx_d = line_idx_q;
        err_ovf_d  = err_ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start && (cfg_pixels != '0) && (cfg_lines != '0)) begin
                    state_d    = StWaitRdy;
                    pix_d      = cfg_pixels;
                    lines_d    = cfg_lines;
                    integ_d    = cfg_integ;
                    line_idx_d = '0;
                    err_ovf_d  = 1'b0;
                end
            end
            StWaitRdy: begin
                if (!fifo_afull) begin
                    state_d = StSh;
                    cnt_d   = '0;
                end
            end
            StSh: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ShLast) begin
                    cnt_d   = '0;
                    state_d = (integ_q == '0) ? StRead : StInteg;
                end
            end
            StInteg: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == integ_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                // The sensor cannot stall, so back-pressure here is only flagged.
                if (fifo_afull) begin
                    err_ovf_d = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == pix_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = StStep;
                end
            end
            StStep: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == StepLast) begin
                    cnt_d = '0;
                    if (line_idx_q == lines_q - 1'b1) begin
                        state_d = StDone;
                    end else begin
                        line_idx_d = line_idx_q + 1'b1;
                        state_d    = StWaitRdy;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides every transition, including a start in the same IDLE cycle.
        if (abort) begin
            state_d    = StIdle;
            cnt_d      = '0;
            line_idx_d = line_idx_q;
            if (state_q == StIdle) begin
                err_ovf_d = err_ovf_q;
            end
        end

        sh_d   = (state_d == StSh);
        lv_d   = (state_d == StRead);
        ms_d   = (state_d == StStep);
        done_d = (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge rx_clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pix_q      <= '0;
            lines_q    <= '0;
            integ_q    <= '0;
            line_idx_q <= '0;
            err_ovf_q  <= 1'b0;
            sh_q       <= 1'b0;
            lv_q       <= 1'b0;
            ms_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pix_q      <= pix_d;
            lines_q    <= lines_d;
            integ_q    <= integ_d;
            line_idx_q <= line_idx_d;
            err_ovf_q  <= err_ovf_d;
            sh_q       <= sh_d;
            lv_q       <= lv_d;
            ms_q       <= ms_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sensor_sh  = sh_q;
    assign line_valid = lv_q;
    assign motor_step = ms_q;
    assign line_idx   = line_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_scan_line_sequencer.sv
// Bench for scan_line_sequencer: expected per-cycle output traces are laid out from the
// frame timing rules, then compared cycle by cycle against the DUT.
module tb_scan_line_sequencer;

    localparam int CW   = 16;
    localparam int SHW  = 2;
    localparam int STW  = 2;
    localparam int NMAX = 400;

    logic          rx_clk = 1'b0;
    logic          nrst;
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_pixels;
    logic [CW-1:0] cfg_lines;
    logic [CW-1:0] cfg_integ;
    logic          fifo_afull;
    logic          sensor_sh;
    logic          line_valid;
    logic          motor_step;
    logic [CW-1:0] line_idx;
    logic          busy;
    logic          done;
    logic          err_ovf;

    always #5 rx_clk = ~rx_clk;

    scan_line_sequencer #(
        .CNT_W      (CW),
        .SH_WIDTH   (SHW),
        .STEP_WIDTH (STW)
    ) dut (
        .rx_clk     (rx_clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .cfg_pixels (cfg_pixels),
        .cfg_lines  (cfg_lines),
        .cfg_integ  (cfg_integ),
        .fifo_afull (fifo_afull),
        .sensor_sh  (sensor_sh),
        .line_valid (line_valid),
        .motor_step (motor_step),
        .line_idx   (line_idx),
        .busy       (busy),
        .done       (done),
        .err_ovf    (err_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit afl[NMAX];
    bit e_sh[NMAX], e_lv[NMAX], e_ms[NMAX], e_dn[NMAX], e_busy[NMAX], e_ovf[NMAX];
    int e_idx[NMAX];
    bit o_sh[NMAX], o_lv[NMAX], o_ms[NMAX], o_dn[NMAX], o_busy[NMAX], o_ovf[NMAX];
    int o_idx[NMAX];
    int idx0 = 0;
    bit ovf0 = 1'b0;

    task automatic chk(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, c, obs, expv);
        end
    endtask

    // Lays out the expected trace; cycle 0 carries start, afl[] is afull per cycle.
    function automatic int build(input int p, input int l, input int integ, input int ab);
        bit valid;
        bit go;
        int t;
        int cur;
        bit cov;
        for (int c = 0; c < NMAX; c++) begin
            e_sh[c] = 0; e_lv[c] = 0; e_ms[c] = 0; e_dn[c] = 0; e_busy[c] = 0;
            e_idx[c] = -1;
        end
        valid = (p != 0) && (l != 0) && (ab != 0);
        t = 1;
        if (valid) begin
            for (int ln = 0; ln < l; ln++) begin
                go = 1'b1;
                while (go && t < NMAX - 100) begin
                    e_busy[t] = 1; e_idx[t] = ln; go = afl[t]; t++;
                end
                for (int k = 0; k < SHW; k++) begin
                    e_sh[t] = 1; e_busy[t] = 1; e_idx[t] = ln; t++;
                end
                for (int k = 0; k < integ; k++) begin
                    e_busy[t] = 1; e_idx[t] = ln; t++;
                end
                for (int k = 0; k < p; k++) begin
                    e_lv[t] = 1; e_busy[t] = 1; e_idx[t] = ln; t++;
                end
                for (int k = 0; k < STW; k++) begin
                    e_ms[t] = 1; e_busy[t] = 1; e_idx[t] = ln; t++;
                end
            end
            e_dn[t] = 1; e_busy[t] = 1; e_idx[t] = l - 1; t++;
            if (ab > 0) begin
                for (int c = ab + 1; c < NMAX; c++) begin
                    e_sh[c] = 0; e_lv[c] = 0; e_ms[c] = 0; e_dn[c] = 0; e_busy[c] = 0;
                    e_idx[c] = -1;
                end
            end
        end
        cur = idx0;
        for (int c = 0; c < NMAX; c++) begin
            if (e_idx[c] >= 0) cur = e_idx[c];
            e_idx[c] = cur;
        end
        cov = ovf0;
        for (int c = 0; c < NMAX; c++) begin
            if (c > 0) begin
                if (valid && c == 1) cov = 1'b0;
                else if (e_lv[c-1] && afl[c-1]) cov = 1'b1;
            end
            e_ovf[c] = cov;
        end
        if (!valid) return 6;
        if (ab > 0) return ab + 4;
        return t + 2;
    endfunction

    task automatic clear_afl(input bit rnd);
        for (int c = 0; c < NMAX; c++) afl[c] = rnd ? ($urandom_range(3) == 0) : 1'b0;
    endtask

    task automatic run(input string tag, input int p, input int l, input int integ,
                       input int ab, input int bs, input int rst_at);
        int len;
        if (ab >= 0) afl[ab] = 1'b0;
        len = build(p, l, integ, ab);
        for (int c = 0; c < len; c++) begin
            start      = (c == 0) || (c == bs);
            abort      = (c == ab);
            fifo_afull = afl[c];
            if (c == 0) begin
                cfg_pixels = CW'(p); cfg_lines = CW'(l); cfg_integ = CW'(integ);
            end else begin
                cfg_pixels = CW'($urandom_range(9));
                cfg_lines  = CW'($urandom_range(3));
                cfg_integ  = CW'($urandom_range(5));
            end
            if (c == rst_at) begin
                #2 nrst = 1'b0;
                #1 chk({tag, "_async_rst"}, c,
                       {busy, sensor_sh, line_valid, motor_step, done, err_ovf, line_idx}, 0);
                start = 0; abort = 0; fifo_afull = 0;
                @(negedge rx_clk) nrst = 1'b1;
                @(posedge rx_clk) #1;
                idx0 = 0; ovf0 = 1'b0;
                return;
            end
            @(negedge rx_clk);
            o_sh[c] = sensor_sh; o_lv[c] = line_valid; o_ms[c] = motor_step;
            o_dn[c] = done; o_busy[c] = busy; o_ovf[c] = err_ovf; o_idx[c] = int'(line_idx);
            chk(tag, c, {busy, sensor_sh, line_valid, motor_step, done, err_ovf, line_idx},
                {e_busy[c], e_sh[c], e_lv[c], e_ms[c], e_dn[c], e_ovf[c], e_idx[c][15:0]});
            @(posedge rx_clk) #1;
        end
        start = 0; abort = 0; fifo_afull = 0;
        idx0 = e_idx[len-1]; ovf0 = e_ovf[len-1];
    endtask

    initial begin
        int s;
        int len0;
        int p, l, ig, ab, bs;
        nrst = 1'b0; start = 0; abort = 0; fifo_afull = 0;
        cfg_pixels = '0; cfg_lines = '0; cfg_integ = '0;
        #3 chk("reset", -1,
               {busy, sensor_sh, line_valid, motor_step, done, err_ovf, line_idx}, 0);
        @(negedge rx_clk) nrst = 1'b1;
        @(posedge rx_clk) #1;

        clear_afl(0);
        run("nominal", 4, 2, 3, -1, -1, -1);
        chk("nom_sh2", 2, o_sh[2], 1);    chk("nom_sh4", 4, o_sh[4], 0);
        chk("nom_lv7", 7, o_lv[7], 1);    chk("nom_lv10", 10, o_lv[10], 1);
        chk("nom_lv11", 11, o_lv[11], 0); chk("nom_ms12", 12, o_ms[12], 1);
        chk("nom_sh14", 14, o_sh[14], 1); chk("nom_lv19", 19, o_lv[19], 1);
        chk("nom_ms24", 24, o_ms[24], 1); chk("nom_done25", 25, o_dn[25], 1);
        chk("nom_busy26", 26, o_busy[26], 0); chk("nom_idx26", 26, o_idx[26], 1);

        clear_afl(0);
        for (int c = 0; c < 20; c++) afl[c] = 1'b1;
        run("backpressure", 4, 2, 3, -1, -1, -1);
        chk("bp_sh20", 20, o_sh[20], 0); chk("bp_sh21", 21, o_sh[21], 1);
        chk("bp_ovf", 30, o_ovf[30], 0);

        clear_afl(0);
        afl[8] = 1'b1;
        run("overflow", 4, 2, 3, -1, -1, -1);
        s = 0;
        for (int c = 0; c < 13; c++) s += int'(o_lv[c]);
        chk("ovf_width", 12, s, 4);
        chk("ovf_pre", 8, o_ovf[8], 0); chk("ovf_set", 9, o_ovf[9], 1);
        chk("ovf_sticky", 27, o_ovf[27], 1); chk("ovf_done", 25, o_dn[25], 1);

        clear_afl(0);
        run("abort", 4, 2, 3, 8, -1, -1);
        chk("ab_lv8", 8, o_lv[8], 1); chk("ab_lv9", 9, o_lv[9], 0);
        chk("ab_busy9", 9, o_busy[9], 0);
        s = 0;
        for (int c = 0; c < 12; c++) s += int'(o_ms[c]) + int'(o_dn[c]);
        chk("ab_no_step_done", 11, s, 0);

        run("integ0", 4, 1, 0, -1, -1, -1);
        chk("i0_lv3", 3, o_lv[3], 0); chk("i0_lv4", 4, o_lv[4], 1);

        run("zero_pix", 0, 2, 3, -1, -1, -1);
        chk("zp_busy", 1, o_busy[1], 0);
        run("zero_lines", 4, 0, 3, -1, -1, -1);
        chk("zl_busy", 1, o_busy[1], 0);
        run("start_abort", 4, 2, 3, 0, -1, -1);
        chk("sa_busy", 1, o_busy[1], 0);

        run("start_busy", 4, 2, 3, -1, 5, -1);
        chk("sb_sh14", 14, o_sh[14], 1); chk("sb_done25", 25, o_dn[25], 1);

        run("rst_integ", 4, 2, 3, -1, -1, 5);
        run("post_rst", 4, 2, 3, -1, -1, -1);
        chk("pr_done25", 25, o_dn[25], 1); chk("pr_idx", 26, o_idx[26], 1);

        for (int k = 0; k < 24; k++) begin
            p  = (k % 8 == 7) ? 0 : int'($urandom_range(6, 1));
            l  = int'($urandom_range(3, 1));
            ig = int'($urandom_range(4));
            clear_afl(1);
            len0 = build(p, l, ig, -1);
            ab = -1;
            bs = -1;
            if (p != 0 && $urandom_range(2) == 0) ab = int'($urandom_range(len0 - 3, 1));
            if (ab >= 0) afl[ab] = 1'b0;
            void'(build(p, l, ig, ab));
            if (p != 0 && $urandom_range(1) == 0) begin
                bs = int'($urandom_range((ab > 0) ? ab : len0 - 3, 1));
                if (e_busy[bs] == 1'b0) bs = -1;
            end
            run("random", p, l, ig, ab, bs, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
